// File: rtl/trigger_pkg.sv
// Shared command encodings and compare modes for the trigger counter bank.
package trigger_pkg;

    localparam logic [1:0] IDL = 2'b00;
    localparam logic [1:0] CLR = 2'b01;
    localparam logic [1:0] INC = 2'b10;
    localparam logic [1:0] DEC = 2'b11;

    typedef enum logic [1:0] {
        EQ = 2'b00,
        NE = 2'b01,
        GE = 2'b10,
        LT = 2'b11
    } cmp_mode_e;

    // Unsigned compare; operands are zero-extended to 32 bits by the caller.
    function automatic logic cmp_eval(input logic [31:0] a, input logic [31:0] b, input cmp_mode_e m);
        logic r;
        case (m)
            EQ:      r = (a == b);
            NE:      r = (a != b);
            GE:      r = (a >= b);
            LT:      r = (a <  b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/trigger_counter_ch.sv
// One trigger counter channel: up/down counter, registered compare, hit pulse, sticky flags.
module trigger_counter_ch
    import trigger_pkg::*;
#(
    parameter int TCW = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic [1:0]     mode,
    input  logic           sat,
    input  logic [TCW-1:0] val,
    input  logic [TCW-1:0] rld,
    input  logic           clr,
    input  logic           transfer,
    input  logic [1:0]     tevent,
    output logic [TCW-1:0] cnt,
    output logic           evt,
    output logic           hit,
    output logic           stk,
    output logic           ovf
);

    localparam logic [TCW-1:0] CNT_MAX = {TCW{1'b1}};
    localparam logic [TCW-1:0] CNT_MIN = {TCW{1'b0}};
    localparam logic [TCW-1:0] CNT_ONE = TCW'(1);

    logic [TCW-1:0] cnt_q, cnt_d;
    logic           evt_q, evt_d;
    logic           hit_q, hit_d;
    logic           stk_q, stk_d;
    logic           ovf_q, ovf_d;
    logic           ovf_set_s;
    logic           cmp_s;

    // Next-state: counter command, compare on the post-update value, sticky set-wins-over-clear.
    always_comb begin
        cnt_d     = cnt_q;
        ovf_set_s = 1'b0;
        if (transfer && ena) begin
            case (tevent)
                IDL: cnt_d = cnt_q;
                CLR: cnt_d = rld;
                INC: begin
                    if (cnt_q == CNT_MAX) begin
                        ovf_set_s = 1'b1;
                        cnt_d     = sat ? cnt_q : CNT_MIN;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                DEC: begin
                    if (cnt_q == CNT_MIN) begin
                        ovf_set_s = 1'b1;
                        cnt_d     = sat ? cnt_q : CNT_MAX;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: cnt_d = cnt_q;
            endcase
        end else begin
            cnt_d = cnt_q;
        end

        cmp_s = ena & cmp_eval(32'(cnt_d), 32'(val), cmp_mode_e'(mode));
        evt_d = cmp_s;
        hit_d = cmp_s & ~evt_q;

        if (hit_d) begin
            stk_d = 1'b1;
        end else if (clr) begin
            stk_d = 1'b0;
        end else begin
            stk_d = stk_q;
        end

        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Channel state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_MIN;
            evt_q <= 1'b0;
            hit_q <= 1'b0;
            stk_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
            hit_q <= hit_d;
            stk_q <= stk_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign evt = evt_q;
    assign hit = hit_q;
    assign stk = stk_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/trigger_counter_bank.sv
// Bank of NCH independent trigger counters; this level only slices the packed vectors.
module trigger_counter_bank
    import trigger_pkg::*;
#(
    parameter int TCW = 32,
    parameter int NCH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       cfg_ena,
    input  logic [2*NCH-1:0]     cfg_mod,
    input  logic [NCH-1:0]       cfg_sat,
    input  logic [TCW*NCH-1:0]   cfg_val,
    input  logic [TCW*NCH-1:0]   cfg_rld,
    input  logic [NCH-1:0]       cfg_clr,
    input  logic                 sti_transfer,
    input  logic [2*NCH-1:0]     sti_tevent,
    output logic [TCW*NCH-1:0]   sts_cnt,
    output logic [NCH-1:0]       sts_evt,
    output logic [NCH-1:0]       sts_hit,
    output logic [NCH-1:0]       sts_stk,
    output logic [NCH-1:0]       sts_ovf
);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        trigger_counter_ch #(.TCW(TCW)) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .ena      (cfg_ena[g]),
            .mode     (cfg_mod[2*g +: 2]),
            .sat      (cfg_sat[g]),
            .val      (cfg_val[TCW*g +: TCW]),
            .rld      (cfg_rld[TCW*g +: TCW]),
            .clr      (cfg_clr[g]),
            .transfer (sti_transfer),
            .tevent   (sti_tevent[2*g +: 2]),
            .cnt      (sts_cnt[TCW*g +: TCW]),
            .evt      (sts_evt[g]),
            .hit      (sts_hit[g]),
            .stk      (sts_stk[g]),
            .ovf      (sts_ovf[g])
        );
    end

endmodule

// File: doc/trigger_counter_bank.md
TRIGGER_COUNTER_BANK -- requirements
Module: trigger_counter_bank

Interface
REQ-001 SHALL have parameter TCW, default 32: counter width per channel, legal range 2..32.
REQ-002 SHALL have parameter NCH, default 4: number of independent counter channels, legal range 1..16.
REQ-003 SHALL have port clk  input  1: the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_ena  input  NCH: per-channel enable.
REQ-006 SHALL have port cfg_mod  input  2*NCH: per-channel compare mode; 00 EQ, 01 NE, 10 GE unsigned, 11 LT unsigned.
REQ-007 SHALL have port cfg_sat  input  NCH: per-channel overflow policy; 1 saturate, 0 wrap.
REQ-008 SHALL have port cfg_val  input  TCW*NCH: per-channel compare value.
REQ-009 SHALL have port cfg_rld  input  TCW*NCH: per-channel value loaded on a clear command.
REQ-010 SHALL have port cfg_clr  input  NCH: per-channel synchronous clear of the sticky flags.
REQ-011 SHALL have port sti_transfer  input  1: stream qualifier; commands act only when high.
REQ-012 SHALL have port sti_tevent  input  2*NCH: per-channel command; 00 idle, 01 clear, 10 increment, 11 decrement.
REQ-013 SHALL have port sts_cnt  output  TCW*NCH: current counter values.
REQ-014 SHALL have port sts_evt  output  NCH: registered compare result level.
REQ-015 SHALL have port sts_hit  output  NCH: one-cycle pulse on a 0->1 transition of sts_evt.
REQ-016 SHALL have port sts_stk  output  NCH: sticky hit flag.
REQ-017 SHALL have port sts_ovf  output  NCH: sticky overflow/underflow flag.
Channel i SHALL use field bits [i*W +: W] of every vector port.

Function
REQ-018 Counter SHALL update only when sti_transfer=1 and cfg_ena[i]=1; otherwise hold.
REQ-019 Clear SHALL load cfg_rld[i]; idle SHALL hold.
REQ-020 Increment at 2^TCW-1 SHALL hold if cfg_sat=1, else wrap to 0; either case SHALL set sts_ovf.
REQ-021 Decrement at 0 SHALL hold if cfg_sat=1, else wrap to 2^TCW-1; either case SHALL set sts_ovf.
REQ-022 sts_evt SHALL register cmp(cnt_next, cfg_val, cfg_mod) at the same edge that updates the counter; zero added latency versus sts_cnt. cfg changes SHALL take effect at the next edge.
REQ-023 sts_evt SHALL be forced to 0 while cfg_ena[i]=0.
REQ-024 sts_hit SHALL be registered as cmp_next & ~sts_evt (pulse width one cycle). It SHALL re-fire only after sts_evt has returned to 0.
REQ-025 sts_stk SHALL set on sts_hit condition; cfg_clr SHALL clear it. Simultaneous set and clear: set SHALL win.
REQ-026 sts_ovf SHALL follow the same set/clear rule with cfg_clr.
REQ-027 Channels SHALL be fully independent; no cross-channel interaction.

Reset
REQ-028 While rst_n=0, all counters, sts_evt, sts_hit, sts_stk and sts_ovf SHALL be 0. This is independent of cfg_rld and cfg_val.
REQ-029 The first edge after release SHALL evaluate the compare normally, e.g. EQ with cfg_val=0 gives sts_evt=1 and sts_hit=1.
REQ-030 Assertion of rst_n mid-count SHALL clear all state immediately, without waiting for clk.

Structure
REQ-031 Package trigger_pkg SHALL hold the command encoding constants (IDL, CLR, INC, DEC) and the compare-mode enum (EQ, NE, GE, LT).
REQ-032 Per-channel logic SHALL be sub-module trigger_counter_ch, instantiated NCH times by generate.
REQ-033 The top level SHALL only slice vectors; no state at top level.

Verification
REQ-034 Scenario TCW=4, cfg_sat=0, 16 INC from 0: expected cnt=0 after the wrap and sts_ovf=1. Then cfg_clr=1 for one cycle: expected sts_ovf=0.
REQ-035 Scenario TCW=4, cfg_sat=1, 20 INC: expected cnt holds at 15 and sts_ovf=1. Then DEC at 0 with sat: expected cnt stays 0.
REQ-036 Scenario EQ, cfg_val=5, INC to 5 then INC, DEC: expected sts_hit pulses at cnt=5 twice and sts_evt is low at cnt=6. GE mode, same stimulus: expected a single hit.
REQ-037 Scenario cfg_rld=9 with CLR: expected cnt=9 next cycle. CLR with sti_transfer=0: expected cnt unchanged.
REQ-038 Scenario NCH=4, channel 2 disabled, all channels INC: expected ch2 cnt frozen with sts_evt=0 and others advancing. Stk set coinciding with cfg_clr: expected sts_stk=1.
REQ-039 Scenario rst_n asserted mid-count at cnt=7, asynchronously: expected all outputs 0 before the next clk edge.
